// File: rtl/booth_mult_seq_ctrl_if.sv
// Stream, multiplier and status bundle for the Booth multiplier sequencer.
// slave = controller side, master = surrounding pipeline / multiplier side.
interface booth_mult_seq_ctrl_if #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int CNT_W          = 16
);
    localparam int OP_W = MANTISSA_WIDTH + 1;
    localparam int PR_W = 2 * MANTISSA_WIDTH + 2;

    logic            s_valid_i;
    logic            s_ready_o;
    logic [OP_W-1:0] s_red_i;
    logic [OP_W-1:0] s_green_i;
    logic [OP_W-1:0] s_blue_i;

    logic            mult_en_o;
    logic [OP_W-1:0] mult_red_o;
    logic [OP_W-1:0] mult_green_o;
    logic [OP_W-1:0] mult_blue_o;
    logic [PR_W-1:0] mult_red_i;
    logic [PR_W-1:0] mult_green_i;
    logic [PR_W-1:0] mult_blue_i;
    logic            mult_done_i;

    logic            m_valid_o;
    logic            m_ready_i;
    logic [PR_W-1:0] m_red_o;
    logic [PR_W-1:0] m_green_o;
    logic [PR_W-1:0] m_blue_o;

    logic             busy_o;
    logic             timeout_o;
    logic [CNT_W-1:0] pix_cnt_o;

    modport slave (
        input  s_valid_i, s_red_i, s_green_i, s_blue_i,
        output s_ready_o,
        output mult_en_o, mult_red_o, mult_green_o, mult_blue_o,
        input  mult_red_i, mult_green_i, mult_blue_i, mult_done_i,
        output m_valid_o, m_red_o, m_green_o, m_blue_o,
        input  m_ready_i,
        output busy_o, timeout_o, pix_cnt_o
    );

    modport master (
        output s_valid_i, s_red_i, s_green_i, s_blue_i,
        input  s_ready_o,
        input  mult_en_o, mult_red_o, mult_green_o, mult_blue_o,
        output mult_red_i, mult_green_i, mult_blue_i, mult_done_i,
        input  m_valid_o, m_red_o, m_green_o, m_blue_o,
        output m_ready_i,
        input  busy_o, timeout_o, pix_cnt_o
    );
endinterface

// File: rtl/booth_mult_seq_ctrl.sv
// Sequencer for the three-channel Booth multiplier: launches one pixel at a
// time, waits for done under a watchdog, and holds the products until taken.
module booth_mult_seq_ctrl #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int TIMEOUT_CYC    = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 clk_i_mult_ctrl,
    input  logic                 rstn_i_mult_ctrl,
    booth_mult_seq_ctrl_if.slave bus
);
    localparam int OP_W  = MANTISSA_WIDTH + 1;
    localparam int PR_W  = 2 * MANTISSA_WIDTH + 2;
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        OUT    = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_mult_en;
    logic [OP_W-1:0]  r_op_red;
    logic [OP_W-1:0]  r_op_green;
    logic [OP_W-1:0]  r_op_blue;
    logic [PR_W-1:0]  r_res_red;
    logic [PR_W-1:0]  r_res_green;
    logic [PR_W-1:0]  r_res_blue;
    logic             r_m_valid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [TMR_W-1:0] r_timer;

    logic w_s_ready;
    logic w_timer_last;

    assign w_s_ready    = (r_state == IDLE);
    assign w_timer_last = (r_timer == TMR_LAST);

    // Enable and valid are registered alongside the state so each leaves the
    // block glitch-free; the async reset still pulls mult_en low at once.
    always_ff @(posedge clk_i_mult_ctrl or negedge rstn_i_mult_ctrl) begin
        if (!rstn_i_mult_ctrl) begin
            r_state     <= IDLE;
            r_mult_en   <= 1'b0;
            r_op_red    <= '0;
            r_op_green  <= '0;
            r_op_blue   <= '0;
            r_res_red   <= '0;
            r_res_green <= '0;
            r_res_blue  <= '0;
            r_m_valid   <= 1'b0;
            r_timeout   <= 1'b0;
            r_pix_cnt   <= '0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.s_valid_i) begin
                        r_op_red   <= bus.s_red_i;
                        r_op_green <= bus.s_green_i;
                        r_op_blue  <= bus.s_blue_i;
                        r_mult_en  <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A done still high from the previous operation is stale here.
                    r_timer <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (bus.mult_done_i) begin
                        r_res_red   <= bus.mult_red_i;
                        r_res_green <= bus.mult_green_i;
                        r_res_blue  <= bus.mult_blue_i;
                        r_mult_en   <= 1'b0;
                        r_m_valid   <= 1'b1;
                        r_state     <= OUT;
                    end else if (w_timer_last) begin
                        r_mult_en <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ERR;
                    end
                end
                OUT: begin
                    if (bus.m_ready_i) begin
                        r_m_valid <= 1'b0;
                        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                        r_state   <= IDLE;
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_mult_en <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready_o    = w_s_ready;
    assign bus.busy_o       = ~w_s_ready;
    assign bus.mult_en_o    = r_mult_en;
    assign bus.mult_red_o   = r_op_red;
    assign bus.mult_green_o = r_op_green;
    assign bus.mult_blue_o  = r_op_blue;
    assign bus.m_valid_o    = r_m_valid;
    assign bus.m_red_o      = r_res_red;
    assign bus.m_green_o    = r_res_green;
    assign bus.m_blue_o     = r_res_blue;
    assign bus.timeout_o    = r_timeout;
    assign bus.pix_cnt_o    = r_pix_cnt;
endmodule
